// File: rtl/alu_op_decoder.sv
// RV32I instruction to ALU control decoder.
// One registered output stage with a 1-entry skid buffer.
module alu_op_decoder #(
    parameter int WIDTH     = 32,
    parameter int CNT_WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 flush,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [WIDTH-1:0]     instr,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [3:0]           alu_cntrl,
    output logic                 src_b_imm,
    output logic                 is_branch,
    output logic                 illegal,
    output logic [CNT_WIDTH-1:0] illegal_cnt
);

    typedef enum logic [3:0] {
        ALU_ADD  = 4'd0,
        ALU_SUB  = 4'd1,
        ALU_AND  = 4'd2,
        ALU_OR   = 4'd3,
        ALU_SLL  = 4'd4,
        ALU_SLT  = 4'd5,
        ALU_SLTU = 4'd6,
        ALU_XOR  = 4'd7,
        ALU_SRL  = 4'd8,
        ALU_SRA  = 4'd9
    } alu_op_e;

    typedef struct packed {
        logic [3:0] alu;
        logic       imm;
        logic       br;
        logic       ill;
    } dec_t;

    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;

    logic [6:0] w_opc;
    logic [2:0] w_f3;
    logic [6:0] w_f7;
    logic       w_unused;
    dec_t       w_dec;
    logic       w_accept;

    dec_t       r_or;
    logic       r_or_valid;
    dec_t       r_sk;
    logic       r_sk_valid;
    logic [CNT_WIDTH-1:0] r_cnt;

    assign w_opc    = instr[6:0];
    assign w_f3     = instr[14:12];
    assign w_f7     = instr[31:25];
    assign w_unused = ^{instr[24:15], instr[11:7]};

    // Plain funct3 to ALU op mapping shared by OP and OP-IMM.
    function automatic logic [3:0] f3_alu(input logic [2:0] f3);
        logic [3:0] op;
        op = ALU_ADD;
        case (f3)
            3'b000:  op = ALU_ADD;
            3'b001:  op = ALU_SLL;
            3'b010:  op = ALU_SLT;
            3'b011:  op = ALU_SLTU;
            3'b100:  op = ALU_XOR;
            3'b101:  op = ALU_SRL;
            3'b110:  op = ALU_OR;
            default: op = ALU_AND;
        endcase
        return op;
    endfunction

    // Combinational decode of the incoming instruction word.
    always_comb begin
        w_dec = '0;
        case (w_opc)
            OPC_OP: begin
                case (w_f3)
                    3'b000: begin
                        if (w_f7 == 7'h00)      w_dec.alu = ALU_ADD;
                        else if (w_f7 == 7'h20) w_dec.alu = ALU_SUB;
                        else                    w_dec.ill = 1'b1;
                    end
                    3'b101: begin
                        if (w_f7 == 7'h00)      w_dec.alu = ALU_SRL;
                        else if (w_f7 == 7'h20) w_dec.alu = ALU_SRA;
                        else                    w_dec.ill = 1'b1;
                    end
                    default: begin
                        if (w_f7 == 7'h00) w_dec.alu = f3_alu(w_f3);
                        else               w_dec.ill = 1'b1;
                    end
                endcase
            end
            OPC_OPIMM: begin
                w_dec.imm = 1'b1;
                case (w_f3)
                    3'b001: begin
                        if (w_f7 == 7'h00) w_dec.alu = ALU_SLL;
                        else               w_dec.ill = 1'b1;
                    end
                    3'b101: begin
                        if (w_f7 == 7'h00)      w_dec.alu = ALU_SRL;
                        else if (w_f7 == 7'h20) w_dec.alu = ALU_SRA;
                        else                    w_dec.ill = 1'b1;
                    end
                    default: w_dec.alu = f3_alu(w_f3);
                endcase
            end
            OPC_LOAD, OPC_STORE, OPC_JALR,
            OPC_LUI, OPC_AUIPC, OPC_JAL: begin
                w_dec.alu = ALU_ADD;
                w_dec.imm = 1'b1;
            end
            OPC_BRANCH: begin
                w_dec.br = 1'b1;
                case (w_f3)
                    3'b000, 3'b001: w_dec.alu = ALU_SUB;
                    3'b100, 3'b101: w_dec.alu = ALU_SLT;
                    3'b110, 3'b111: w_dec.alu = ALU_SLTU;
                    default:        w_dec.ill = 1'b1;
                endcase
            end
            default: w_dec.ill = 1'b1;
        endcase
        // Illegal ops carry no other information.
        if (w_dec.ill) begin
            w_dec.alu = ALU_ADD;
            w_dec.imm = 1'b0;
            w_dec.br  = 1'b0;
        end
    end

    assign in_ready = !r_sk_valid;
    assign w_accept = in_valid && in_ready;

    // Output register and skid buffer; OR fields zeroed whenever empty.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_or       <= '0;
            r_or_valid <= 1'b0;
            r_sk       <= '0;
            r_sk_valid <= 1'b0;
        end else if (flush) begin
            r_or       <= '0;
            r_or_valid <= 1'b0;
            r_sk       <= '0;
            r_sk_valid <= 1'b0;
        end else if (r_or_valid && r_sk_valid) begin
            if (out_ready) begin
                r_or       <= r_sk;
                r_sk       <= '0;
                r_sk_valid <= 1'b0;
            end
        end else if (w_accept && (!r_or_valid || out_ready)) begin
            r_or       <= w_dec;
            r_or_valid <= 1'b1;
        end else if (w_accept) begin
            r_sk       <= w_dec;
            r_sk_valid <= 1'b1;
        end else if (r_or_valid && out_ready) begin
            r_or       <= '0;
            r_or_valid <= 1'b0;
        end
    end

    // Saturating count of accepted illegal instructions.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (!flush && w_accept && w_dec.ill && (r_cnt != '1)) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    assign out_valid   = r_or_valid;
    assign alu_cntrl   = r_or.alu;
    assign src_b_imm   = r_or.imm;
    assign is_branch   = r_or.br;
    assign illegal     = r_or.ill;
    assign illegal_cnt = r_cnt;

endmodule

// File: tb/tb_alu_op_decoder.sv
// Directed self-checking bench for alu_op_decoder.
// Inputs change 1ns after the rising edge, outputs checked there too.
module tb_alu_op_decoder;

    logic        clk;
    logic        rst_n;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] instr;
    logic        out_valid;
    logic        out_ready;
    logic [3:0]  alu_cntrl;
    logic        src_b_imm;
    logic        is_branch;
    logic        illegal;
    logic [7:0]  illegal_cnt;

    int n_tests = 0;
    int n_fail  = 0;

    alu_op_decoder #(.WIDTH(32), .CNT_WIDTH(8)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .flush      (flush),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .instr      (instr),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .alu_cntrl  (alu_cntrl),
        .src_b_imm  (src_b_imm),
        .is_branch  (is_branch),
        .illegal    (illegal),
        .illegal_cnt(illegal_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_out(input string tag, input logic v,
                           input logic [3:0] a, input logic imm,
                           input logic br, input logic ill);
        chk({tag, ".valid"}, {31'd0, out_valid}, {31'd0, v});
        chk({tag, ".alu"},   {28'd0, alu_cntrl}, {28'd0, a});
        chk({tag, ".imm"},   {31'd0, src_b_imm}, {31'd0, imm});
        chk({tag, ".br"},    {31'd0, is_branch}, {31'd0, br});
        chk({tag, ".ill"},   {31'd0, illegal},   {31'd0, ill});
    endtask

    initial begin
        rst_n     = 1'b0;
        flush     = 1'b0;
        in_valid  = 1'b0;
        instr     = 32'h0;
        out_ready = 1'b0;

        // 1. reset
        tick();
        tick();
        chk_out("rst", 1'b0, 4'd0, 1'b0, 1'b0, 1'b0);
        rst_n = 1'b1;
        tick();
        chk("rst.in_ready", {31'd0, in_ready}, 32'd1);
        chk("rst.cnt", {24'd0, illegal_cnt}, 32'd0);
        chk_out("idle", 1'b0, 4'd0, 1'b0, 1'b0, 1'b0);

        // 2. back-to-back sub, srai, slt, latency 1
        out_ready = 1'b1;
        in_valid  = 1'b1;
        instr     = 32'h40208033;
        tick();
        chk_out("sub", 1'b1, 4'd1, 1'b0, 1'b0, 1'b0);
        instr = 32'h4020D093;
        tick();
        chk_out("srai", 1'b1, 4'd9, 1'b1, 1'b0, 1'b0);
        instr = 32'h0020A133;
        tick();
        chk_out("slt", 1'b1, 4'd5, 1'b0, 1'b0, 1'b0);

        // extra patterns: lw, bad slli f7, jal
        instr = 32'h00002083;
        tick();
        chk_out("lw", 1'b1, 4'd0, 1'b1, 1'b0, 1'b0);
        instr = 32'h40001093;
        tick();
        chk_out("slli_bad", 1'b1, 4'd0, 1'b0, 1'b0, 1'b1);
        chk("slli_bad.cnt", {24'd0, illegal_cnt}, 32'd1);
        instr = 32'h0000006F;
        tick();
        chk_out("jal", 1'b1, 4'd0, 1'b1, 1'b0, 1'b0);

        // 3. branches
        instr = 32'h00C5C463;
        tick();
        chk_out("blt", 1'b1, 4'd5, 1'b0, 1'b1, 1'b0);
        instr = 32'h00002063;
        tick();
        chk_out("br010", 1'b1, 4'd0, 1'b0, 1'b0, 1'b1);
        chk("br010.cnt", {24'd0, illegal_cnt}, 32'd2);
        in_valid = 1'b0;
        tick();
        chk_out("drain", 1'b0, 4'd0, 1'b0, 1'b0, 1'b0);

        // 4. backpressure fills OR then skid
        out_ready = 1'b0;
        in_valid  = 1'b1;
        instr     = 32'h40208033;
        tick();
        chk_out("bp.or", 1'b1, 4'd1, 1'b0, 1'b0, 1'b0);
        chk("bp.rdy1", {31'd0, in_ready}, 32'd1);
        instr = 32'h0020A133;
        tick();
        chk("bp.rdy0", {31'd0, in_ready}, 32'd0);
        chk_out("bp.hold", 1'b1, 4'd1, 1'b0, 1'b0, 1'b0);
        instr = 32'h4020D093;
        tick();
        chk("bp.rdy0b", {31'd0, in_ready}, 32'd0);
        chk_out("bp.hold2", 1'b1, 4'd1, 1'b0, 1'b0, 1'b0);
        in_valid  = 1'b0;
        out_ready = 1'b1;
        tick();
        chk_out("bp.second", 1'b1, 4'd5, 1'b0, 1'b0, 1'b0);
        chk("bp.rdy_back", {31'd0, in_ready}, 32'd1);
        tick();
        chk_out("bp.empty", 1'b0, 4'd0, 1'b0, 1'b0, 1'b0);

        // 5. flush with OR and SK full and an illegal instr offered
        out_ready = 1'b0;
        in_valid  = 1'b1;
        instr     = 32'h40208033;
        tick();
        instr = 32'h0020A133;
        tick();
        chk("fl.full", {31'd0, in_ready}, 32'd0);
        flush = 1'b1;
        instr = 32'hFFFFFFFF;
        tick();
        chk_out("fl", 1'b0, 4'd0, 1'b0, 1'b0, 1'b0);
        chk("fl.rdy", {31'd0, in_ready}, 32'd1);
        chk("fl.cnt", {24'd0, illegal_cnt}, 32'd2);
        flush    = 1'b0;
        in_valid = 1'b0;
        out_ready = 1'b1;
        tick();
        chk_out("fl.after", 1'b0, 4'd0, 1'b0, 1'b0, 1'b0);

        // 6. saturation of the illegal counter
        in_valid = 1'b1;
        instr    = 32'hFFFFFFFF;
        for (int i = 0; i < 300; i++) tick();
        chk("sat.cnt", {24'd0, illegal_cnt}, 32'd255);
        chk_out("sat", 1'b1, 4'd0, 1'b0, 1'b0, 1'b1);
        tick();
        chk("sat.hold", {24'd0, illegal_cnt}, 32'd255);

        // asynchronous reset between edges
        #2;
        rst_n = 1'b0;
        #1;
        chk_out("arst", 1'b0, 4'd0, 1'b0, 1'b0, 1'b0);
        chk("arst.cnt", {24'd0, illegal_cnt}, 32'd0);
        in_valid = 1'b0;
        #1;
        rst_n = 1'b1;
        tick();
        chk("arst.rdy", {31'd0, in_ready}, 32'd1);
        chk_out("arst.idle", 1'b0, 4'd0, 1'b0, 1'b0, 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
